seg_scan_display: RTL and testbench

Consumer end of the `clk_div` output: takes the `clk_mux` scan strobe plus a binary distance from the ultrasound range path and drives a 4-digit, common-anode, multiplexed seven-segment display. A sequential binary-to-BCD converter (shift-add-3) turns each accepted distance into three decimal digits. The block then scans one digit per `clk_mux` rising edge, blanking leading zeros and showing dashes on overflow.

---
 rtl/seg_scan_display_if.sv | 30 +++
 rtl/seg_scan_display.sv | 217 +++++++++++++++++++++
 tb/tb_seg_scan_display.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: bundles the scan strobe, distance load port and
// display drive signals of seg_scan_display.
//   clk_mux    - scan strobe from clk_div (sampled as data)
//   dist_valid - one-cycle load request for dist_cm
//   dist_cm    - unsigned distance in cm, 0..1023
//   busy       - conversion in progress
//   an         - digit anodes, active-low, bit 0 = units
//   seg        - segments {g,f,e,d,c,b,a}, active-low
//   dp         - decimal point, active-low
interface seg_scan_display_if;
   logic       clk_mux;
   logic       dist_valid;
   logic [9:0] dist_cm;
   logic       busy;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   // Producer side: range path plus clock divider, observes the display
   modport master (
      output clk_mux, dist_valid, dist_cm,
      input  busy, an, seg, dp
   );

   // Display controller side
   modport slave (
      input  clk_mux, dist_valid, dist_cm,
      output busy, an, seg, dp
   );
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: converts an accepted binary distance to three BCD digits
// with a sequential shift-add-3 converter, then scans a 4-digit common-anode
// seven-segment display one digit per clk_mux rising edge, blanking leading
// zeros (BLANK_LZ) and showing dashes when the distance exceeds 999.
//   clk  - system clock, all logic on the rising edge
//   rst  - synchronous active-high reset
//   bus  - seg_scan_display_if.slave (clk_mux, dist_valid, dist_cm in;
//          busy, an, seg, dp out)
module seg_scan_display #(
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   seg_scan_display_if.slave          bus
);

   localparam int unsigned DIST_W  = 10;
   localparam int unsigned BCD_W   = 12;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned AN_W    = 4;
   localparam int unsigned SEG_W   = 7;
   localparam int unsigned ITER    = 10;
   localparam int unsigned MAX_DEC = 999;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      LOAD = 2'd2
   } state_t;

   typedef struct packed {
      logic       ovf;
      logic [3:0] hun;
      logic [3:0] ten;
      logic [3:0] uni;
   } disp_t;

   state_t              state_q, state_d;
   logic [DIST_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   disp_t               disp_q, disp_d;
   logic                busy_q, busy_d;
   logic                sync1_q, sync1_d;
   logic                sync2_q, sync2_d;
   logic                sync3_q, sync3_d;
   logic                started_q, started_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [AN_W-1:0]     an_q, an_d;
   logic [SEG_W-1:0]    seg_q, seg_d;

   logic                     scan_rise_c;
   logic [BCD_W+DIST_W-1:0]  shift_c;

   // Active-low segment pattern for one BCD digit; out-of-range decodes blank
   function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Add 3 to every BCD nibble that is 5 or more before the next shift
   function automatic logic [BCD_W-1:0] bcd_adj(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < 3; i++) begin
         if (r[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = 4'(r[i*4 +: 4] + 4'd3);
         end
      end
      return r;
   endfunction

   // Segment pattern for a digit position given the display contents
   function automatic logic [SEG_W-1:0] digit_seg(input logic [IDX_W-1:0] idx,
                                                  input disp_t d);
      logic [SEG_W-1:0] s;
      s = SEG_BLANK;
      if (d.ovf) begin
         s = SEG_DASH;
      end else begin
         case (idx)
            2'd0: s = seg_code(d.uni);
            2'd1: s = (BLANK_LZ && d.hun == 4'd0 && d.ten == 4'd0) ?
                      SEG_BLANK : seg_code(d.ten);
            2'd2: s = (BLANK_LZ && d.hun == 4'd0) ? SEG_BLANK : seg_code(d.hun);
            default: s = SEG_BLANK;
         endcase
      end
      return s;
   endfunction

   // Rising edge of the synchronized scan strobe
   assign scan_rise_c = sync2_q & ~sync3_q;

   // Next-state logic for converter, display register and scanner
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      disp_d    = disp_q;
      started_d = started_q;
      idx_d     = idx_q;
      shift_c   = {bcd_adj(bcd_q), bin_q};

      sync1_d = bus.clk_mux;
      sync2_d = sync1_q;
      sync3_d = sync2_q;

      case (state_q)
         IDLE: begin
            if (bus.dist_valid) begin
               bin_d   = bus.dist_cm;
               bcd_d   = '0;
               cnt_d   = '0;
               ovf_d   = (bus.dist_cm > DIST_W'(MAX_DEC));
               state_d = CONV;
            end
         end
         CONV: begin
            // One shift-add-3 iteration: adjusted BCD and remaining binary
            // shift left together as a single register
            {bcd_d, bin_d} = {shift_c[BCD_W+DIST_W-2:0], 1'b0};
            cnt_d = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            disp_d.ovf = ovf_q;
            disp_d.hun = bcd_q[11:8];
            disp_d.ten = bcd_q[7:4];
            disp_d.uni = bcd_q[3:0];
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);

      // First detected edge selects digit 0; later edges advance and wrap
      if (scan_rise_c) begin
         idx_d     = started_q ? IDX_W'(idx_q + 1'b1) : '0;
         started_d = 1'b1;
      end

      // Outputs use next index and next display data so a commit and a scan
      // step on the same cycle show up together
      if (started_d) begin
         an_d  = AN_W'(~(AN_W'(1) << idx_d));
         seg_d = digit_seg(idx_d, disp_d);
      end else begin
         an_d  = '1;
         seg_d = SEG_BLANK;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         disp_q    <= '0;
         busy_q    <= 1'b0;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync3_q   <= 1'b0;
         started_q <= 1'b0;
         idx_q     <= '0;
         an_q      <= '1;
         seg_q     <= SEG_BLANK;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         disp_q    <= disp_d;
         busy_q    <= busy_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         sync3_q   <= sync3_d;
         started_q <= started_d;
         idx_q     <= idx_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.an   = an_q;
   assign bus.seg  = seg_q;
   assign bus.dp   = 1'b1;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
   localparam logic [6:0] SB = 7'b1111111;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   seg_scan_display_if bus ();

   seg_scan_display #(.BLANK_LZ(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // One full clk_mux pulse; the scan output settles before this returns
   task automatic scan_pulse();
      @(negedge clk);
      bus.clk_mux = 1'b1;
      repeat (3) @(negedge clk);
      bus.clk_mux = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic scan_check(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
      scan_pulse();
      chk({tag, "_an"}, 16'(bus.an), 16'(an_e));
      chk({tag, "_seg"}, 16'(bus.seg), 16'(seg_e));
   endtask

   // Four scan steps starting at digit 0 (scan must currently sit on digit 3)
   task automatic show4(input string tag, input logic [6:0] u, input logic [6:0] t,
                        input logic [6:0] h, input logic [6:0] d3);
      scan_check({tag, "_d0"}, 4'b1110, u);
      scan_check({tag, "_d1"}, 4'b1101, t);
      scan_check({tag, "_d2"}, 4'b1011, h);
      scan_check({tag, "_d3"}, 4'b0111, d3);
   endtask

   task automatic load(input logic [9:0] v);
      @(negedge clk);
      bus.dist_cm    = v;
      bus.dist_valid = 1'b1;
      @(negedge clk);
      bus.dist_valid = 1'b0;
   endtask

   // Counts busy cycles until idle; a stuck busy is reported as a failure
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("busy_timeout", 16'(bus.busy), 16'd0);
   endtask

   int n;

   initial begin
      errors         = 0;
      checks         = 0;
      rst            = 1'b1;
      bus.clk_mux    = 1'b0;
      bus.dist_valid = 1'b0;
      bus.dist_cm    = '0;

      // Reset with the strobe toggling
      for (int i = 0; i < 3; i++) begin
         bus.clk_mux = ~bus.clk_mux;
         @(negedge clk);
         chk("rst_an", 16'(bus.an), 16'hF);
         chk("rst_seg", 16'(bus.seg), 16'(SB));
         chk("rst_busy", 16'(bus.busy), 16'd0);
         chk("rst_dp", 16'(bus.dp), 16'd1);
      end
      bus.clk_mux = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_an", 16'(bus.an), 16'hF);
      chk("post_rst_seg", 16'(bus.seg), 16'(SB));
      chk("post_rst_busy", 16'(bus.busy), 16'd0);

      // 257: busy for exactly 11 cycles, then scan
      load(10'd257);
      wait_idle(n);
      chk("busy_len", 16'(n), 16'd11);
      show4("d257", S7, S5, S2, SB);

      // Leading-zero blanking
      load(10'd5);
      wait_idle(n);
      show4("d005", S5, SB, SB, SB);
      load(10'd40);
      wait_idle(n);
      show4("d040", S0, S4, SB, SB);

      // Overflow and recovery
      load(10'd1000);
      wait_idle(n);
      show4("d1000", SD, SD, SD, SD);
      load(10'd999);
      wait_idle(n);
      show4("d999", S9, S9, S9, SB);

      // Load while busy is dropped
      load(10'd257);
      @(negedge clk);
      load(10'd42);
      wait_idle(n);
      show4("drop42", S7, S5, S2, SB);
      load(10'd42);
      wait_idle(n);
      show4("d042", S2, S4, SB, SB);

      // Reset five cycles into a conversion
      load(10'd888);
      repeat (4) @(negedge clk);
      chk("conv_busy", 16'(bus.busy), 16'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_an", 16'(bus.an), 16'hF);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", 16'(bus.busy), 16'd0);
      chk("mid_rst_an2", 16'(bus.an), 16'hF);
      show4("after_rst", S0, SB, SB, SB);

      // Held-high strobe advances exactly once
      @(negedge clk);
      bus.clk_mux = 1'b1;
      repeat (5) @(negedge clk);
      chk("hold_first_an", 16'(bus.an), 16'b1110);
      repeat (95) @(negedge clk);
      chk("hold_high_an", 16'(bus.an), 16'b1110);
      chk("hold_high_seg", 16'(bus.seg), 16'(S0));
      bus.clk_mux = 1'b0;
      repeat (20) @(negedge clk);
      chk("hold_low_an", 16'(bus.an), 16'b1110);
      chk("dp_const", 16'(bus.dp), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
